// File: rtl/tube_pkg.sv
// Shared register map, CTRL layout and FSM encoding for the tube display controller.
`timescale 1ns/1ps
package tube_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned HALF_W  = 16;
  localparam int unsigned CTRL_W  = 4;

  localparam logic [3:0] TUBE_DATA   = 4'h0;
  localparam logic [3:0] TUBE_CTRL   = 4'h4;
  localparam logic [3:0] TUBE_PERIOD = 4'h8;
  localparam logic [3:0] TUBE_STATUS = 4'hC;

  localparam int unsigned CTRL_ON     = 0;
  localparam int unsigned CTRL_SCROLL = 1;
  localparam int unsigned CTRL_SRC    = 2;
  localparam int unsigned CTRL_PAGE   = 3;

  // Field order mirrors the bit indices above (page is the MSB, on the LSB)
  typedef struct packed {
    logic page;
    logic src;
    logic scroll;
    logic on;
  } tube_ctrl_t;

  typedef enum logic [1:0] {
    OFF = 2'd0,
    LO  = 2'd1,
    HI  = 2'd2
  } tube_state_e;

  // Halfword presented to the tube for a given display state
  function automatic logic [HALF_W-1:0] shown_half(input tube_state_e st,
                                                   input logic [WORD_W-1:0] w);
    logic [HALF_W-1:0] s;
    case (st)
      LO:      s = w[HALF_W-1:0];
      HI:      s = w[WORD_W-1:HALF_W];
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/tube_scroll_timer.sv
// Scroll step timer: counts clk cycles while enabled and flags the cycle where count+1 reaches period.
`timescale 1ns/1ps
module tube_scroll_timer
  import tube_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic              clear,
  input  logic [WORD_W-1:0] period,
  output logic              toggle_c
);

  logic [WORD_W-1:0] cnt_q;
  logic              wrap;

  // count < period always holds while running, so count+1 cannot overflow
  assign wrap     = (period != '0) && ((cnt_q + WORD_W'(1)) == period);
  assign toggle_c = en && !clear && wrap;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (clear || !en || period == '0 || wrap) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + WORD_W'(1);
    end
  end

endmodule

// File: rtl/tube_display_ctrl.sv
// Bus slave that arbitrates a 32-bit word between CPU and debug sources and pages it onto a 16-bit tube driver.
`timescale 1ns/1ps
module tube_display_ctrl
  import tube_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 25_000_000,
  parameter logic [31:0] PERIOD_RST = 32'd25_000_000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        sel,
  input  logic        we,
  input  logic [3:0]  addr,
  input  logic [3:0]  byte_en,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        dbg_valid,
  input  logic [31:0] dbg_data,
  output logic        dbg_ready,
  output logic        tube_en,
  output logic [15:0] tube_data
);

  // Clock frequency is informational only
  localparam int unsigned UNUSED_CLK_HZ = CLK_HZ;

  logic [WORD_W-1:0] data_q, data_nxt;
  logic [WORD_W-1:0] period_q;
  logic [WORD_W-1:0] dbg_q;
  logic              dbg_held_q;
  tube_ctrl_t        ctrl_q, ctrl_nxt;
  tube_state_e       state_q;

  logic              wr, wr_data, wr_ctrl, wr_period;
  logic              dbg_fire;
  logic              scroll_en, scroll_clear, toggle_c;
  logic [WORD_W-1:0] word_w;
  logic [HALF_W-1:0] shown;
  logic              unused_addr_lsb;

  assign unused_addr_lsb = &{1'b0, addr[1:0]};

  // Bus decode; only addr[3:2] selects a register
  assign wr        = sel && we;
  assign wr_data   = wr && (addr[3:2] == TUBE_DATA[3:2]);
  assign wr_ctrl   = wr && (addr[3:2] == TUBE_CTRL[3:2]) && byte_en[0];
  assign wr_period = wr && (addr[3:2] == TUBE_PERIOD[3:2]) && (byte_en == 4'hF);

  // dbg_ready is the registered src bit, so a same-cycle CTRL write cannot affect a handshake
  assign dbg_ready = ctrl_q.src;
  assign dbg_fire  = dbg_valid && ctrl_q.src;

  always_comb begin
    data_nxt = data_q;
    if (wr_data) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) data_nxt[8*b +: 8] = wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    ctrl_nxt = ctrl_q;
    if (wr_ctrl) ctrl_nxt = tube_ctrl_t'(wdata[CTRL_W-1:0]);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_q     <= '0;
      ctrl_q     <= '0;
      period_q   <= PERIOD_RST;
      dbg_q      <= '0;
      dbg_held_q <= 1'b0;
    end else begin
      data_q <= data_nxt;
      ctrl_q <= ctrl_nxt;
      if (wr_period) period_q <= wdata;
      if (dbg_fire) begin
        dbg_q      <= dbg_data;
        dbg_held_q <= 1'b1;
      end
    end
  end

  // Counter restarts on a PERIOD write and when scroll mode is switched on
  assign scroll_en    = ctrl_q.on && ctrl_q.scroll && (state_q != OFF);
  assign scroll_clear = wr_period || (ctrl_nxt.scroll && !ctrl_q.scroll);

  tube_scroll_timer u_timer (
    .clk      (clk),
    .rstn     (rstn),
    .en       (scroll_en),
    .clear    (scroll_clear),
    .period   (period_q),
    .toggle_c (toggle_c)
  );

  // Display FSM; decisions use the post-write CTRL so a CTRL write overrides a scroll step
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= OFF;
    end else if (!ctrl_nxt.on) begin
      state_q <= OFF;
    end else begin
      case (state_q)
        OFF: state_q <= LO;
        default: begin
          if (!ctrl_nxt.scroll) begin
            state_q <= ctrl_nxt.page ? HI : LO;
          end else if (toggle_c && !wr_ctrl) begin
            state_q <= (state_q == HI) ? LO : HI;
          end
        end
      endcase
    end
  end

  assign word_w = ctrl_q.src ? dbg_q : data_q;
  assign shown  = shown_half(state_q, word_w);

  // Load pulse accompanies every change of the registered halfword
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tube_data <= '0;
      tube_en   <= 1'b0;
    end else begin
      tube_data <= shown;
      tube_en   <= (shown != tube_data);
    end
  end

  always_comb begin
    rdata = '0;
    case (addr[3:2])
      TUBE_DATA[3:2]:   rdata = data_q;
      TUBE_CTRL[3:2]:   rdata = {(WORD_W-CTRL_W)'(0), ctrl_q};
      TUBE_PERIOD[3:2]: rdata = period_q;
      default:          rdata = {(WORD_W-2)'(0), dbg_held_q, state_q == HI};
    endcase
  end

endmodule
